// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: FSM state encoding, ALU opcodes,
// instruction field positions and datapath widths.
package cpu_pkg;

  localparam int REG_W   = 8;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // Sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Register-type (type=0) ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;
  localparam logic [3:0] OP_CLR  = 4'd14;
  localparam logic [3:0] OP_NEG  = 4'd15;

  // Control-type (type=1) opcodes; anything else is undefined
  localparam logic [3:0] OP_JMP  = 4'd0;
  localparam logic [3:0] OP_DJ   = 4'd1;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Instruction field bit positions (rs overlaps the jump address)
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int TYPE_BIT = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 9;
  localparam int RS_MSB   = 8;
  localparam int RS_LSB   = 7;
  localparam int JA_MSB   = 7;
  localparam int JA_LSB   = 0;

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: two combinational operand read ports, a combinational
// debug read port and one synchronous write port.
module regfile4x8
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [1:0]       raddr1,
  input  logic [1:0]       raddr2,
  input  logic [1:0]       dbg_sel,
  output logic [REG_W-1:0] rdata1,
  output logic [REG_W-1:0] rdata2,
  output logic [REG_W-1:0] dbg_data
);

  logic [REG_W-1:0] regs [4];

  // Register storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute controller for the 8-bit CPU. Owns the PC and register file,
// fetches instructions over a req/ack handshake, presents operands to the
// external combinational ALU and commits its result and next-PC.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  alu_opcode,
  output logic        alu_type,
  output logic [7:0]  alu_reg1,
  output logic [7:0]  alu_reg2,
  output logic [7:0]  alu_pc,
  output logic [7:0]  alu_jmpadd,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_next,
  input  logic        alu_load,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam logic [3:0] TO_LIMIT = 4'(ACK_TIMEOUT);

  logic [1:0]         state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         ack_cnt;

  logic [3:0]      opcode;
  logic            typ;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic            is_jmp;
  logic            is_dj;
  logic            is_halt;
  logic            is_undef;
  logic            in_exec;
  logic            wb_en;
  logic [PC_W-1:0] pc_inc;
  logic [3:0]      cnt_inc;
  logic            timeout_hit;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign typ    = instr[TYPE_BIT];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];

  assign is_jmp   = typ && (opcode == OP_JMP);
  assign is_dj    = typ && (opcode == OP_DJ);
  assign is_halt  = typ && (opcode == OP_HALT);
  assign is_undef = typ && !(is_jmp || is_dj || is_halt);

  assign in_exec     = (state == ST_EXEC);
  assign wb_en       = in_exec && (!typ || is_dj);
  assign pc_inc      = pc + 8'd1;
  assign cnt_inc     = ack_cnt + 4'd1;
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  regfile4x8 u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_en),
    .waddr    (rd),
    .wdata    (alu_out),
    .raddr1   (rd),
    .raddr2   (rs),
    .dbg_sel  (dbg_sel),
    .rdata1   (alu_reg1),
    .rdata2   (alu_reg2),
    .dbg_data (dbg_data)
  );

  // Control FSM: state, ack timeout counter, sticky fault and illegal pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ack_cnt <= '0;
      fault   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ack_cnt <= '0;
            state   <= ST_EXEC;
          end else if (timeout_hit) begin
            ack_cnt <= cnt_inc;
            fault   <= 1'b1;
            state   <= ST_HALTED;
          end else begin
            ack_cnt <= cnt_inc;
          end
        end
        ST_EXEC: begin
          illegal <= is_undef;
          if (is_halt)  state <= ST_HALTED;
          else if (run) state <= ST_FETCH;
          else          state <= ST_IDLE;
        end
        default: begin
          // A fault pins the sequencer here until reset
          if (!run && !fault) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: instruction latch on ack, PC commit at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (state == ST_FETCH && imem_ack) instr <= imem_data;
      if (in_exec) begin
        if ((is_jmp || is_dj) && alu_load) pc <= alu_next;
        else                               pc <= pc_inc;
      end
    end
  end

  assign imem_req   = (state == ST_FETCH);
  assign imem_addr  = pc;
  assign alu_opcode = opcode;
  assign alu_type   = typ;
  assign alu_pc     = pc;
  assign alu_jmpadd = instr[JA_MSB:JA_LSB];
  assign busy       = (state == ST_FETCH) || (state == ST_EXEC);
  assign halted     = (state == ST_HALTED);

endmodule
